add_sub_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one `iadder` 32-bit add/sub datapath between NUM_REQ requesters.
- Each requester uses a valid/ready request channel. One shared response channel returns the result tagged with the requester ID.
- The block instantiates `iadder` internally. It sits between the ALU issue logic and any unit that needs address or offset arithmetic.

---
 rtl/add_sub_arbiter.sv | 161 ++++++++++++++++
 tb/tb_add_sub_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_arbiter.sv
// Round-robin arbiter sharing one 32-bit iadder between NUM_REQ valid/ready requesters.
// Optional ADD_SUB_ARB_PERF_EN adds perf_ops/perf_ovf response counters.

module iadder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        add_sub,
    input  logic        carry_in,
    output logic [31:0] sum_dif,
    output logic        c,
    output logic        v
);
    logic [31:0] b_eff;

    // Subtract is a + ~b + carry_in; the caller forces carry_in to 1 for subtracts.
    always_comb begin
        b_eff        = add_sub ? ~b : b;
        {c, sum_dif} = {1'b0, a} + {1'b0, b_eff} + {32'b0, carry_in};
        v            = (a[31] == b_eff[31]) && (sum_dif[31] != a[31]);
    end
endmodule

module add_sub_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    input  logic [NUM_REQ-1:0]    req_add_sub,
    input  logic [NUM_REQ-1:0]    req_carry_in,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_sum_dif,
    output logic                  rsp_c,
    output logic                  rsp_v
`ifdef ADD_SUB_ARB_PERF_EN
    ,
    output logic [31:0]           perf_ops,
    output logic [31:0]           perf_ovf
`endif
);
    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e          state_q;
    logic [ID_W-1:0] rr_ptr_q;
    logic [31:0]     a_q;
    logic [31:0]     b_q;
    logic            add_sub_q;
    logic            cin_q;
    logic [ID_W-1:0] id_q;

    logic            grant_en;
    logic            found;
    logic            grant;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] next_ptr;
    logic            grant_cin;
    int              idx;

    logic [31:0]     add_sum_dif;
    logic            add_c;
    logic            add_v;

    iadder u_iadder (
        .a        (a_q),
        .b        (b_q),
        .add_sub  (add_sub_q),
        .carry_in (cin_q),
        .sum_dif  (add_sum_dif),
        .c        (add_c),
        .v        (add_v)
    );

    // Search from rr_ptr upward with wrap; the first valid requester wins.
    always_comb begin
        grant_en  = (state_q == StIdle) || ((state_q == StResp) && rsp_ready);
        found     = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= int'(NUM_REQ)) begin
                idx = idx - int'(NUM_REQ);
            end
            if (!found && req_valid[idx]) begin
                found     = 1'b1;
                grant_idx = ID_W'(idx);
            end
        end
        grant     = grant_en && found;
        req_ready = '0;
        if (grant) begin
            req_ready[grant_idx] = 1'b1;
        end
        next_ptr  = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        grant_cin = req_add_sub[grant_idx] ? 1'b1 : req_carry_in[grant_idx];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            add_sub_q   <= 1'b0;
            cin_q       <= 1'b0;
            id_q        <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_sum_dif <= '0;
            rsp_c       <= 1'b0;
            rsp_v       <= 1'b0;
`ifdef ADD_SUB_ARB_PERF_EN
            perf_ops    <= '0;
            perf_ovf    <= '0;
`endif
        end else begin
            if (grant) begin
                a_q       <= req_a[32*grant_idx +: 32];
                b_q       <= req_b[32*grant_idx +: 32];
                add_sub_q <= req_add_sub[grant_idx];
                cin_q     <= grant_cin;
                id_q      <= grant_idx;
                rr_ptr_q  <= next_ptr;
            end
            unique case (state_q)
                StIdle: begin
                    if (grant) begin
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    rsp_sum_dif <= add_sum_dif;
                    rsp_c       <= add_c;
                    rsp_v       <= add_v;
                    rsp_id      <= id_q;
                    rsp_valid   <= 1'b1;
                    state_q     <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= grant ? StExec : StIdle;
`ifdef ADD_SUB_ARB_PERF_EN
                        perf_ops  <= perf_ops + 32'd1;
                        if (rsp_v) begin
                            perf_ovf <= perf_ovf + 32'd1;
                        end
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_add_sub_arbiter.sv
// Directed self-checking bench for add_sub_arbiter (4 requesters).

module tb_add_sub_arbiter;
    localparam int NR = 4;

    logic             clk_i;
    logic             rst_ni;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*32-1:0] req_a;
    logic [NR*32-1:0] req_b;
    logic [NR-1:0]    req_add_sub;
    logic [NR-1:0]    req_carry_in;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic [31:0]      rsp_sum_dif;
    logic             rsp_c;
    logic             rsp_v;
`ifdef ADD_SUB_ARB_PERF_EN
    logic [31:0]      perf_ops;
    logic [31:0]      perf_ovf;
`endif

    int total = 0;
    int bad   = 0;

    add_sub_arbiter #(.NUM_REQ(NR), .ID_W(2)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_add_sub  (req_add_sub),
        .req_carry_in (req_carry_in),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_sum_dif  (rsp_sum_dif),
        .rsp_c        (rsp_c),
        .rsp_v        (rsp_v)
`ifdef ADD_SUB_ARB_PERF_EN
        ,
        .perf_ops     (perf_ops),
        .perf_ovf     (perf_ovf)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_req(input int i, input logic [31:0] a, input logic [31:0] b,
                             input logic as, input logic cin);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_add_sub[i]    = as;
        req_carry_in[i]   = cin;
        req_valid[i]      = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni       = 1'b0;
        req_valid    = '0;
        req_a        = '0;
        req_b        = '0;
        req_add_sub  = '0;
        req_carry_in = '0;
        rsp_ready    = 1'b1;
        tick();
        tick();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", rsp_valid); end
        total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL rst_id got=%0d exp=0", rsp_id); end
        total++; if (rsp_sum_dif !== 32'h0) begin bad++; $display("FAIL rst_sum got=%h exp=0", rsp_sum_dif); end
        total++; if (rsp_c !== 1'b0) begin bad++; $display("FAIL rst_c got=%b exp=0", rsp_c); end
        total++; if (rsp_v !== 1'b0) begin bad++; $display("FAIL rst_v got=%b exp=0", rsp_v); end
        total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0000", req_ready); end
        rst_ni = 1'b1;
        tick();
    endtask

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] a;
        logic [31:0] b;
        logic        as;
        logic        cin;
        logic [31:0] sum;
        logic        c;
        logic        v;
    } vec_t;

    task automatic test_arith();
        vec_t vecs[6];
        vecs[0] = '{2'd0, 32'h0000_0005, 32'h0000_000A, 1'b0, 1'b0, 32'h0000_000F, 1'b0, 1'b0};
        vecs[1] = '{2'd2, 32'h0000_000A, 32'h0000_0014, 1'b1, 1'b0, 32'hFFFF_FFF6, 1'b0, 1'b0};
        vecs[2] = '{2'd1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[3] = '{2'd2, 32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
        vecs[4] = '{2'd3, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0003, 1'b0, 1'b0};
        vecs[5] = '{2'd3, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        for (int n = 0; n < 6; n++) begin
            logic [3:0] exp_rdy;
            exp_rdy = 4'b0001 << vecs[n].id;
            drive_req(int'(vecs[n].id), vecs[n].a, vecs[n].b, vecs[n].as, vecs[n].cin);
            #1;
            total++;
            if (req_ready !== exp_rdy) begin
                bad++; $display("FAIL arith%0d_ready got=%b exp=%b", n, req_ready, exp_rdy);
            end
            tick();
            req_valid = '0;
            total++;
            if (rsp_valid !== 1'b0) begin bad++; $display("FAIL arith%0d_early got=%b exp=0", n, rsp_valid); end
            tick();
            total++;
            if (rsp_valid !== 1'b1) begin bad++; $display("FAIL arith%0d_valid got=%b exp=1", n, rsp_valid); end
            total++;
            if (rsp_id !== vecs[n].id) begin
                bad++; $display("FAIL arith%0d_id got=%0d exp=%0d", n, rsp_id, vecs[n].id);
            end
            total++;
            if (rsp_sum_dif !== vecs[n].sum) begin
                bad++; $display("FAIL arith%0d_sum got=%h exp=%h", n, rsp_sum_dif, vecs[n].sum);
            end
            total++;
            if (rsp_c !== vecs[n].c) begin bad++; $display("FAIL arith%0d_c got=%b exp=%b", n, rsp_c, vecs[n].c); end
            total++;
            if (rsp_v !== vecs[n].v) begin bad++; $display("FAIL arith%0d_v got=%b exp=%b", n, rsp_v, vecs[n].v); end
            tick();
            total++;
            if (rsp_valid !== 1'b0) begin bad++; $display("FAIL arith%0d_done got=%b exp=0", n, rsp_valid); end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] r;
        int         n;
        int         last;
        n    = 0;
        last = 0;
        for (int i = 0; i < NR; i++) begin
            drive_req(i, 32'(i), 32'd100, 1'b0, 1'b0);
        end
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            r = req_ready;
            total++;
            if ($countones(r) > 1) begin bad++; $display("FAIL rr_onehot got=%b exp=onehot_or_zero", r); end
            if (rsp_valid) begin
                if (n < NR) begin
                    total++;
                    if (rsp_id !== 2'(n)) begin bad++; $display("FAIL rr_id got=%0d exp=%0d", rsp_id, n); end
                    total++;
                    if (rsp_sum_dif !== 32'(n + 100)) begin
                        bad++; $display("FAIL rr_sum got=%0d exp=%0d", rsp_sum_dif, n + 100);
                    end
                    if (n > 0) begin
                        total++;
                        if (cyc - last != 2) begin
                            bad++; $display("FAIL rr_spacing got=%0d exp=2", cyc - last);
                        end
                    end
                end
                last = cyc;
                n++;
            end
            tick();
            req_valid = req_valid & ~r;
        end
        total++;
        if (n != NR) begin bad++; $display("FAIL rr_count got=%0d exp=%0d", n, NR); end
    endtask

    task automatic test_back_to_back();
        rsp_ready = 1'b0;
        drive_req(1, 32'd1, 32'd2, 1'b0, 1'b0);
        tick();
        req_valid = '0;
        tick();
        drive_req(2, 32'h10, 32'h20, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            #1;
            total++;
            if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b exp=1", rsp_valid); end
            total++;
            if (rsp_id !== 2'd1) begin bad++; $display("FAIL bp_id got=%0d exp=1", rsp_id); end
            total++;
            if (rsp_sum_dif !== 32'd3) begin bad++; $display("FAIL bp_sum got=%h exp=3", rsp_sum_dif); end
            total++;
            if (rsp_c !== 1'b0 || rsp_v !== 1'b0) begin
                bad++; $display("FAIL bp_flags got=%b%b exp=00", rsp_c, rsp_v);
            end
            total++;
            if (req_ready !== 4'b0) begin bad++; $display("FAIL bp_ready got=%b exp=0000", req_ready); end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0100) begin bad++; $display("FAIL b2b_ready got=%b exp=0100", req_ready); end
        tick();
        req_valid = '0;
        total++;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_exec got=%b exp=0", rsp_valid); end
        // Now in EXEC for requester 2; reset drops it.
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        total++;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mrst_valid got=%b exp=0", rsp_valid); end
        total++;
        if (rsp_sum_dif !== 32'h0) begin bad++; $display("FAIL mrst_sum got=%h exp=0", rsp_sum_dif); end
        total++;
        if (rsp_id !== 2'd0) begin bad++; $display("FAIL mrst_id got=%0d exp=0", rsp_id); end
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mrst_stale got=%b exp=0", rsp_valid); end
        end
        drive_req(0, 32'd8, 32'd2, 1'b1, 1'b0);
        drive_req(3, 32'd100, 32'd200, 1'b0, 1'b0);
        #1;
        total++;
        if (req_ready !== 4'b0001) begin bad++; $display("FAIL mrst_ptr got=%b exp=0001", req_ready); end
        tick();
        req_valid[0] = 1'b0;
        tick();
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum_dif !== 32'd6 || rsp_c !== 1'b1) begin
            bad++;
            $display("FAIL post_rst_rsp0 got=%b/%0d/%h/%b exp=1/0/6/1", rsp_valid, rsp_id, rsp_sum_dif,
                     rsp_c);
        end
        #1;
        total++;
        if (req_ready !== 4'b1000) begin bad++; $display("FAIL post_rst_ready got=%b exp=1000", req_ready); end
        tick();
        req_valid = '0;
        tick();
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_sum_dif !== 32'h12C) begin
            bad++;
            $display("FAIL post_rst_rsp3 got=%b/%0d/%h exp=1/3/12c", rsp_valid, rsp_id, rsp_sum_dif);
        end
        tick();
`ifdef ADD_SUB_ARB_PERF_EN
        total++;
        if (perf_ops !== 32'd2) begin bad++; $display("FAIL perf_ops got=%0d exp=2", perf_ops); end
        total++;
        if (perf_ovf !== 32'd0) begin bad++; $display("FAIL perf_ovf got=%0d exp=0", perf_ovf); end
`endif
    endtask

    initial begin
        test_reset();
        test_arith();
        test_round_robin();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
